// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: issues one imem read at a time and buffers {pc, instr, fault} in a small FIFO for decode.
// Optional IFETCH_MISALIGN_EN turns misaligned PCs into NOP fault entries instead of memory reads.
module ifetch_unit #(
   parameter int DEPTH   = 2,
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pc_valid,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_ready,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_fault,
   input  logic               instr_ready,
   input  logic               flush
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t             state;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [ADDR_W-1:0]  mem_pc    [DEPTH];

   logic               accept, misaligned, push_en, pop_en;
   logic [INSTR_W-1:0] push_instr;
   logic [ADDR_W-1:0]  push_pc;

   assign pc_ready = (state == IDLE) && (count < DEPTH_CNT) && !flush;
   assign accept   = pc_valid && pc_ready;
   assign pop_en   = (count != '0) && instr_ready && !flush;

`ifdef IFETCH_MISALIGN_EN
   logic       push_fault;
   logic       mem_fault [DEPTH];
   assign misaligned = (pc_in[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // A push comes either from a memory ack in WAIT or, with the alignment check, from a rejected PC in IDLE
   always_comb begin
      push_en    = 1'b0;
      push_pc    = imem_addr;
      push_instr = imem_rdata;
`ifdef IFETCH_MISALIGN_EN
      push_fault = 1'b0;
`endif
      if (state == WAIT && imem_ack && !flush) push_en = 1'b1;
`ifdef IFETCH_MISALIGN_EN
      if (accept && misaligned) begin
         push_en    = 1'b1;
         push_pc    = pc_in;
         push_instr = INSTR_W'(32'h0000_0013);
         push_fault = 1'b1;
      end
`endif
   end

   // Request FSM; a flushed request stays on the bus in DROP until memory acks it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= '0;
      end else begin
         case (state)
            IDLE: if (accept && !misaligned) begin
               imem_addr <= pc_in;
               imem_req  <= 1'b1;
               state     <= WAIT;
            end
            WAIT: if (imem_ack) begin
               imem_req <= 1'b0;
               state    <= IDLE;
            end else if (flush) begin
               state <= DROP;
            end
            DROP: if (imem_ack) begin
               imem_req <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               imem_req <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_instr[wr_ptr] <= push_instr;
         mem_pc[wr_ptr]    <= push_pc;
`ifdef IFETCH_MISALIGN_EN
         mem_fault[wr_ptr] <= push_fault;
`endif
      end
   end

   assign instr_valid = (count != '0);
   assign instr       = instr_valid ? mem_instr[rd_ptr] : '0;
   assign instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;
`ifdef IFETCH_MISALIGN_EN
   assign instr_fault = instr_valid ? mem_fault[rd_ptr] : 1'b0;
`else
   assign instr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a cycle-by-cycle vector table plus hand sequences
// for reset during a request and the misaligned-PC path (both IFETCH_MISALIGN_EN builds).
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_valid;
   logic [63:0] pc_in;
   logic        pc_ready;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_fault;
   logic        instr_ready;
   logic        flush;

   int total_checks = 0;
   int passed_checks = 0;

   ifetch_unit #(.DEPTH(2), .ADDR_W(64), .INSTR_W(32)) dut (
      .clk(clk), .reset(reset),
      .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_fault(instr_fault), .instr_ready(instr_ready), .flush(flush)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [63:0] pc;
      logic        ack;
      logic [31:0] rd;
      logic        rdy;
      logic        fl;
      logic        e_pr;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_val;
      logic [31:0] e_instr;
      logic [63:0] e_ipc;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic pv, input logic [63:0] pc, input logic ack,
                          input logic [31:0] rd, input logic rdy, input logic fl,
                          input logic e_pr, input logic e_req, input logic [63:0] e_addr,
                          input logic e_val, input logic [31:0] e_instr, input logic [63:0] e_ipc);
      vec_t v;
      v.pv = pv; v.pc = pc; v.ack = ack; v.rd = rd; v.rdy = rdy; v.fl = fl;
      v.e_pr = e_pr; v.e_req = e_req; v.e_addr = e_addr;
      v.e_val = e_val; v.e_instr = e_instr; v.e_ipc = e_ipc;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs at the falling edge and settle; the next rising edge consumes them
   task automatic apply_stimulus(input logic pv, input logic [63:0] pc, input logic ack,
                                 input logic [31:0] rd, input logic rdy, input logic fl);
      @(negedge clk);
      pc_valid = pv; pc_in = pc; imem_ack = ack; imem_rdata = rd;
      instr_ready = rdy; flush = fl;
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total_checks++;
      if (actual === expected) passed_checks++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
   endtask

   initial begin
      reset = 1'b1;
      pc_valid = 1'b0; pc_in = '0; imem_ack = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; flush = 1'b0;

      #12;
      check_output("reset imem_req", {63'd0, imem_req}, 64'd0);
      check_output("reset imem_addr", imem_addr, 64'd0);
      check_output("reset instr_valid", {63'd0, instr_valid}, 64'd0);
      check_output("reset instr", {32'd0, instr}, 64'd0);
      check_output("reset instr_pc", instr_pc, 64'd0);
      check_output("reset instr_fault", {63'd0, instr_fault}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      //       pv  pc      ack rd            rdy fl | pr  req addr    val instr         ipc
      // Single fetch acked in its first request cycle
      add_vec(1, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h00, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 1, 32'h00500093, 0, 0,  0, 1, 64'h00, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        1, 0,  1, 0, 64'h00, 1, 32'h00500093, 64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h00, 0, 32'h0,        64'h00);
      // Three PCs, 3-cycle memory, decode stalled until the FIFO fills
      add_vec(1, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h00, 0, 32'h0,        64'h00);
      add_vec(1, 64'h04, 0, 32'h0,        0, 0,  0, 1, 64'h00, 0, 32'h0,        64'h00);
      add_vec(1, 64'h04, 0, 32'h0,        0, 0,  0, 1, 64'h00, 0, 32'h0,        64'h00);
      add_vec(1, 64'h04, 1, 32'h11111111, 0, 0,  0, 1, 64'h00, 0, 32'h0,        64'h00);
      add_vec(1, 64'h04, 0, 32'h0,        0, 0,  1, 0, 64'h00, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 0, 32'h0,        0, 0,  0, 1, 64'h04, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 0, 32'h0,        0, 0,  0, 1, 64'h04, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 1, 32'h22222222, 0, 0,  0, 1, 64'h04, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 0, 32'h0,        0, 0,  0, 0, 64'h04, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 0, 32'h0,        1, 0,  0, 0, 64'h04, 1, 32'h11111111, 64'h00);
      add_vec(1, 64'h08, 0, 32'h0,        1, 0,  1, 0, 64'h04, 1, 32'h22222222, 64'h04);
      add_vec(0, 64'h00, 0, 32'h0,        1, 0,  0, 1, 64'h08, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 1, 32'h33333333, 1, 0,  0, 1, 64'h08, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        1, 0,  1, 0, 64'h08, 1, 32'h33333333, 64'h08);
      add_vec(0, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h08, 0, 32'h0,        64'h00);
      // Flush in the second WAIT cycle: DROP holds the request, ack two cycles later is discarded
      add_vec(1, 64'h10, 0, 32'h0,        0, 0,  1, 0, 64'h08, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        0, 0,  0, 1, 64'h10, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        0, 1,  0, 1, 64'h10, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        0, 1,  0, 1, 64'h10, 0, 32'h0,        64'h00);
      add_vec(1, 64'h14, 1, 32'hDEADBEEF, 0, 0,  0, 1, 64'h10, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h10, 0, 32'h0,        64'h00);
      // flush coinciding with ack while one entry is buffered
      add_vec(1, 64'h20, 0, 32'h0,        0, 0,  1, 0, 64'h10, 0, 32'h0,        64'h00);
      add_vec(0, 64'h00, 1, 32'hAAAA0001, 0, 0,  0, 1, 64'h20, 0, 32'h0,        64'h00);
      add_vec(1, 64'h24, 0, 32'h0,        0, 0,  1, 0, 64'h20, 1, 32'hAAAA0001, 64'h20);
      add_vec(0, 64'h00, 1, 32'hAAAA0002, 1, 1,  0, 1, 64'h24, 1, 32'hAAAA0001, 64'h20);
      add_vec(0, 64'h00, 0, 32'h0,        0, 0,  1, 0, 64'h24, 0, 32'h0,        64'h00);

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].pv, vecs[i].pc, vecs[i].ack, vecs[i].rd, vecs[i].rdy, vecs[i].fl);
         check_output($sformatf("v%0d pc_ready", i), {63'd0, pc_ready}, {63'd0, vecs[i].e_pr});
         check_output($sformatf("v%0d imem_req", i), {63'd0, imem_req}, {63'd0, vecs[i].e_req});
         check_output($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         check_output($sformatf("v%0d instr_valid", i), {63'd0, instr_valid}, {63'd0, vecs[i].e_val});
         check_output($sformatf("v%0d instr", i), {32'd0, instr}, {32'd0, vecs[i].e_instr});
         check_output($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].e_ipc);
         check_output($sformatf("v%0d instr_fault", i), {63'd0, instr_fault}, 64'd0);
      end

      // Reset asserted mid-request with one entry buffered clears everything without waiting for an edge
      apply_stimulus(1, 64'h30, 0, 32'h0, 0, 0);
      check_output("rst seq pc_ready", {63'd0, pc_ready}, 64'd1);
      apply_stimulus(0, 64'h00, 1, 32'h0BADF00D, 0, 0);
      apply_stimulus(1, 64'h20, 0, 32'h0, 0, 0);
      check_output("rst seq buffered", {63'd0, instr_valid}, 64'd1);
      apply_stimulus(0, 64'h00, 0, 32'h0, 0, 0);
      check_output("rst seq req in WAIT", {63'd0, imem_req}, 64'd1);
      check_output("rst seq addr in WAIT", imem_addr, 64'h20);
      #1 reset = 1'b1;
      #1;
      check_output("async rst imem_req", {63'd0, imem_req}, 64'd0);
      check_output("async rst imem_addr", imem_addr, 64'd0);
      check_output("async rst instr_valid", {63'd0, instr_valid}, 64'd0);
      check_output("async rst instr", {32'd0, instr}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      apply_stimulus(1, 64'h40, 0, 32'h0, 0, 0);
      check_output("post rst pc_ready", {63'd0, pc_ready}, 64'd1);
      apply_stimulus(0, 64'h00, 1, 32'h00A00113, 0, 0);
      check_output("post rst imem_req", {63'd0, imem_req}, 64'd1);
      check_output("post rst imem_addr", imem_addr, 64'h40);
      apply_stimulus(0, 64'h00, 0, 32'h0, 1, 0);
      check_output("post rst instr", {32'd0, instr}, 64'h00A00113);
      check_output("post rst instr_pc", instr_pc, 64'h40);
      apply_stimulus(0, 64'h00, 0, 32'h0, 0, 0);
      check_output("post rst popped", {63'd0, instr_valid}, 64'd0);

      // Misaligned PC 0x6
      apply_stimulus(1, 64'h06, 0, 32'h0, 0, 0);
      check_output("mis pc_ready", {63'd0, pc_ready}, 64'd1);
`ifdef IFETCH_MISALIGN_EN
      apply_stimulus(0, 64'h00, 0, 32'h0, 0, 0);
      check_output("mis no imem_req", {63'd0, imem_req}, 64'd0);
      check_output("mis instr_valid", {63'd0, instr_valid}, 64'd1);
      check_output("mis instr nop", {32'd0, instr}, 64'h13);
      check_output("mis instr_pc", instr_pc, 64'h06);
      check_output("mis instr_fault", {63'd0, instr_fault}, 64'd1);
      check_output("mis pc_ready idle", {63'd0, pc_ready}, 64'd1);
`else
      apply_stimulus(0, 64'h00, 1, 32'h12345678, 0, 0);
      check_output("mis imem_req", {63'd0, imem_req}, 64'd1);
      check_output("mis imem_addr", imem_addr, 64'h06);
      apply_stimulus(0, 64'h00, 0, 32'h0, 0, 0);
      check_output("mis instr_valid", {63'd0, instr_valid}, 64'd1);
      check_output("mis instr", {32'd0, instr}, 64'h12345678);
      check_output("mis instr_pc", instr_pc, 64'h06);
      check_output("mis instr_fault", {63'd0, instr_fault}, 64'd0);
`endif
      apply_stimulus(0, 64'h00, 0, 32'h0, 1, 0);
      apply_stimulus(0, 64'h00, 0, 32'h0, 0, 0);
      check_output("mis popped", {63'd0, instr_valid}, 64'd0);
      check_output("mis popped fault", {63'd0, instr_fault}, 64'd0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch unit. Consumes PC values from the program counter and issues instruction-memory reads.
- Buffers returned instructions, paired with their PC, in a small FIFO. Presents them to decode through a valid/ready handshake.
- Sits between prog_counter and the decode stage.
- Handles branch-redirect flushes, including discarding an in-flight memory response.

Parameters:
DEPTH, 2, FIFO entries; power of two, >=2
ADDR_W, 64, PC / memory address width
INSTR_W, 32, instruction width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_valid  input  1  pc_in holds a PC to fetch
pc_in  input  ADDR_W  PC from prog_counter
pc_ready  output  1  PC accepted this cycle when pc_valid&&pc_ready
imem_req  output  1  memory read request, held until imem_ack
imem_addr  output  ADDR_W  read address, stable while imem_req=1
imem_ack  input  1  read complete; imem_rdata valid this cycle
imem_rdata  input  INSTR_W  fetched instruction
instr_valid  output  1  FIFO head valid
instr  output  INSTR_W  FIFO head instruction
instr_pc  output  ADDR_W  PC of FIFO head
instr_fault  output  1  FIFO head is a misaligned-fetch fault entry
instr_ready  input  1  decode pops head when instr_valid&&instr_ready
flush  input  1  redirect: discard buffered and in-flight fetches

Behaviour:
- Clock and reset: clk; reset asynchronous, active-high.
- Reset state: FSM=IDLE; FIFO empty; imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, instr_fault=0.
- Reset mid-request drops imem_req immediately. The memory must tolerate an abandoned request on reset.
- FSM states: IDLE (nothing outstanding), WAIT (request outstanding), DROP (outstanding request whose response is to be discarded).
- pc_ready is combinational: (state==IDLE) && (count<DEPTH) && !flush.
- Accepting a PC in IDLE latches pc_in into imem_addr and goes to WAIT. imem_req is registered, so it rises the cycle after acceptance.
- Single outstanding request. count<DEPTH at acceptance guarantees the FIFO slot.
- WAIT, imem_ack && !flush:
  - push {imem_addr, imem_rdata, fault=0} into the FIFO;
  - imem_req=0 next cycle; go to IDLE.
- WAIT, flush && !imem_ack: go to DROP. imem_req stays 1 and imem_addr stays stable until ack; the protocol forbids withdrawing a request.
- WAIT, flush && imem_ack: discard rdata; go to IDLE.
- DROP: pc_ready=0. On imem_ack, discard rdata, imem_req=0, go to IDLE. A further flush in DROP has no extra effect.
- Latency: a PC accepted in cycle N raises imem_req in N+1. Ack in cycle M>=N+1 writes the FIFO at the end of M, and the entry is visible at M+1.
  - Minimum PC-to-instr_valid latency is 2 cycles.
  - Peak throughput is 1 instruction per 2 cycles, since acceptance happens only in IDLE.
- FIFO:
  - instr/instr_pc/instr_fault show the head entry; all are 0 when empty.
  - instr_valid = (count!=0).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Pop when empty is ignored. Push when full cannot occur.
- flush:
  - Sets count and pointers to 0 at the next edge, so instr_valid=0 the following cycle.
  - A pop in the same cycle is ignored.
  - Any push that cycle is suppressed.
  - flush while in IDLE affects only the FIFO.
- pc_in is 64-bit and is passed to imem_addr unmodified. No arithmetic is done here; PC+4 belongs to prog_counter.

Optional Feature:
Macro IFETCH_MISALIGN_EN.
- Defined:
  - An accepted PC with pc_in[1:0]!=0 issues no memory request and stays in IDLE.
  - At the next edge it pushes {pc_in, 32'h00000013 (NOP), fault=1}.
  - instr_fault reflects the head entry.
- Undefined:
  - No alignment check; every PC goes to memory as-is.
  - The fault bit is always 0 and instr_fault is tied to 0.

Test Plan:
- Reset, then pc_in=0x0, pc_valid=1, memory acks in the first req cycle with 0x00500093 -> imem_req high cycle 1; instr_valid high cycle 2 with instr=0x00500093, instr_pc=0x0.
- PCs 0x0, 0x4, 0x8 with instr_ready=0, 3-cycle memory latency -> two entries buffered; pc_ready=0 while count=2. Raising instr_ready pops in order 0x0, 0x4, then 0x8 is fetched.
- Flush in the second WAIT cycle for PC 0x10, ack 2 cycles later -> state DROP, imem_req held, rdata discarded, FIFO empty, pc_ready=1 again after ack.
- flush && imem_ack in the same cycle with one buffered entry -> nothing pushed; instr_valid=0 next cycle; state IDLE.
- Assert reset while in WAIT with addr 0x20 -> imem_req, instr_valid and FIFO cleared immediately; the first post-reset PC 0x40 fetches normally.
- With IFETCH_MISALIGN_EN, pc_in=0x6 -> no imem_req; entry instr=0x00000013, instr_pc=0x6, instr_fault=1. Without the macro -> imem_addr=0x6, instr_fault=0.
